multi_tone_selector: RTL

Parametrised successor of the single-bin frequency selector. Watches the channelised FFT stream and extracts up to N_TONES bins per frame, each tagged with a tone index. Results go out on an AXI-Stream master with real backpressure through an internal FIFO. Tone table is double-buffered (shadow/active) so reconfiguration never tears a frame. Sits between the channeliser FFT output and the downstream tone packetiser/DMA.

---
 rtl/multi_tone_selector.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_tone_selector.sv
// -----------------------------------------------------------------------------
// multi_tone_selector
//
// Watches a channelised FFT stream and extracts up to N_TONES bins per frame.
// Each extracted sample is tagged with a tone index from a double-buffered
// tone table. Results leave on an AXI-Stream master through a
// first-word-fall-through FIFO with real backpressure.
//
// The tone table has a shadow copy and an active copy. cfg_* writes go to the
// shadow copy. A commit copies the whole shadow table to the active copy only
// at a frame boundary, so a reconfiguration never tears a frame.
//
// Optional feature macro: FRAME_SEQ_EN
//   defined   -> an 8-bit frame counter is appended as the tuser LSBs
//                (tuser = {index, k, seq}).
//   undefined -> tuser = {index, k}.
//
// Ports:
//   dev_clk, dev_rst        clock, synchronous active-high reset
//   data_in/k_in            FFT sample and its bin number
//   valid_in/last_in        sample valid, last bin of frame
//   cfg_we/cfg_slot/cfg_k/cfg_index/cfg_enable
//                           shadow table slot write
//   cfg_commit              request a shadow->active copy at the next boundary
//   cfg_clr                 clear overflow and drop_cnt
//   m_axis_*                AXI-Stream master (tdata, tvalid, tready, tuser, tlast)
//   en, n_active            active table status
//   commit_pending          commit requested but not yet applied
//   overflow, drop_cnt      sticky drop flag and saturating drop counter
// -----------------------------------------------------------------------------
module multi_tone_selector #(
  parameter int DATA_W     = 64,
  parameter int K_W        = 14,
  parameter int IDX_W      = 7,
  parameter int N_TONES    = 8,
  parameter int FIFO_DEPTH = 16,
`ifdef FRAME_SEQ_EN
  localparam int SEQ_W     = 8,
`else
  localparam int SEQ_W     = 0,
`endif
  localparam int USER_W    = IDX_W + K_W + SEQ_W,
  localparam int SLOT_W    = $clog2(N_TONES),
  localparam int CNT_W     = SLOT_W + 1
) (
  input  logic              dev_clk,
  input  logic              dev_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [K_W-1:0]    k_in,
  input  logic              valid_in,
  input  logic              last_in,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [K_W-1:0]    cfg_k,
  input  logic [IDX_W-1:0]  cfg_index,
  input  logic              cfg_enable,
  input  logic              cfg_commit,
  input  logic              cfg_clr,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              en,
  output logic [CNT_W-1:0]  n_active,
  output logic              commit_pending,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = DATA_W + USER_W + 1;

  // ---------------- tone tables ----------------
  logic             r_sh_en  [N_TONES];
  logic [K_W-1:0]   r_sh_k   [N_TONES];
  logic [IDX_W-1:0] r_sh_idx [N_TONES];
  logic             r_act_en [N_TONES];
  logic [K_W-1:0]   r_act_k  [N_TONES];
  logic [IDX_W-1:0] r_act_idx[N_TONES];

  logic             r_commit_pending;
  logic             r_mid_frame;     // a beat was accepted since the last last_in
  logic [CNT_W-1:0] r_n_active;
  logic             r_en;
  logic [CNT_W-1:0] w_sh_count;
  logic             w_boundary;
  logic             w_commit_req;
  logic             w_do_commit;

  // A boundary is the last_in beat itself, or an idle gap between frames.
  // A beat that opens a new frame is not a boundary, so that frame is matched
  // against a single table from its first bin.
  assign w_boundary   = valid_in ? last_in : !r_mid_frame;
  assign w_commit_req = r_commit_pending | cfg_commit;
  assign w_do_commit  = w_commit_req & w_boundary;

  always_comb begin
    w_sh_count = '0;
    for (int i = 0; i < N_TONES; i++)
      w_sh_count = w_sh_count + CNT_W'(r_sh_en[i]);
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      for (int i = 0; i < N_TONES; i++) begin
        r_sh_en[i]   <= 1'b0;
        r_sh_k[i]    <= '0;
        r_sh_idx[i]  <= '0;
        r_act_en[i]  <= 1'b0;
        r_act_k[i]   <= '0;
        r_act_idx[i] <= '0;
      end
      r_commit_pending <= 1'b0;
      r_mid_frame      <= 1'b0;
      r_n_active       <= '0;
      r_en             <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_sh_en[cfg_slot]  <= cfg_enable;
        r_sh_k[cfg_slot]   <= cfg_k;
        r_sh_idx[cfg_slot] <= cfg_index;
      end
      if (w_do_commit) begin
        for (int i = 0; i < N_TONES; i++) begin
          r_act_en[i]  <= r_sh_en[i];
          r_act_k[i]   <= r_sh_k[i];
          r_act_idx[i] <= r_sh_idx[i];
        end
        r_n_active <= w_sh_count;
        r_en       <= (w_sh_count != '0);
      end
      r_commit_pending <= w_commit_req & !w_boundary;
      if (valid_in)
        r_mid_frame <= !last_in;
    end
  end

  // ---------------- stage 1: parallel match ----------------
  logic [N_TONES-1:0] w_match;
  logic               w_hit;
  logic [SLOT_W-1:0]  w_sel;

  for (genvar gi = 0; gi < N_TONES; gi++) begin : g_match
    assign w_match[gi] = r_act_en[gi] && (r_act_k[gi] == k_in);
  end

  // Scan from the top so the lowest-numbered matching slot is left in w_sel.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N_TONES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_sel = SLOT_W'(i);
      end
    end
  end

  logic              r_s1_valid;
  logic              r_s1_hit;
  logic              r_s1_last;
  logic [DATA_W-1:0] r_s1_data;
  logic [K_W-1:0]    r_s1_k;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [CNT_W-1:0]  r_s1_nact;   // n_active of the table that matched this beat

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_k     <= '0;
      r_s1_idx   <= '0;
      r_s1_nact  <= '0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_hit   <= valid_in & w_hit;
      r_s1_last  <= last_in;
      r_s1_data  <= data_in;
      r_s1_k     <= k_in;
      r_s1_idx   <= r_act_idx[w_sel];
      r_s1_nact  <= r_n_active;
    end
  end

  logic [USER_W-1:0] w_s1_user;
`ifdef FRAME_SEQ_EN
  logic [7:0] r_seq;
  logic [7:0] r_s1_seq;
  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      r_seq    <= '0;
      r_s1_seq <= '0;
    end else begin
      r_s1_seq <= r_seq;
      if (valid_in && last_in)
        r_seq <= r_seq + 8'd1;
    end
  end
  assign w_s1_user = {r_s1_idx, r_s1_k, r_s1_seq};
`else
  assign w_s1_user = {r_s1_idx, r_s1_k};
`endif

  // ---------------- stage 2: hit counting and FIFO write ----------------
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W:0]   w_hit_next;
  logic             w_tlast_flag;

  // One extra bit so a saturated hit_cnt cannot alias onto a small n_active.
  assign w_hit_next   = {1'b0, r_hit_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_tlast_flag = (w_hit_next == {1'b0, r_s1_nact}) || r_s1_last;

  always_ff @(posedge dev_clk) begin
    if (dev_rst)
      r_hit_cnt <= '0;
    else if (r_s1_valid && r_s1_last)
      r_hit_cnt <= '0;
    else if (r_s1_hit && (r_hit_cnt != '1))
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
  end

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_nonempty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [WORD_W-1:0] w_rd_word;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop      = w_nonempty && m_axis_tready;
  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign w_push     = r_s1_hit && (!w_full || w_pop);
  assign w_drop     = r_s1_hit && w_full && !w_pop;

  always_ff @(posedge dev_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {r_s1_data, w_s1_user, w_tlast_flag};
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  logic        r_overflow;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge dev_clk) begin
    if (dev_rst || cfg_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // ---------------- outputs ----------------
  // The head word is read straight out of the array; outputs are forced to
  // zero while empty so nothing stale is presented.
  assign w_rd_word      = r_mem[r_rd_ptr];
  assign m_axis_tvalid  = w_nonempty;
  assign m_axis_tdata   = w_nonempty ? w_rd_word[WORD_W-1 -: DATA_W] : '0;
  assign m_axis_tuser   = w_nonempty ? w_rd_word[USER_W:1] : '0;
  assign m_axis_tlast   = w_nonempty & w_rd_word[0];
  assign en             = r_en;
  assign n_active       = r_n_active;
  assign commit_pending = r_commit_pending;
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop_cnt;

endmodule
